// File: rtl/sc_lane_scheduler.sv
// Play-time sequencer for the Frogger playfield: game tick prescaler, per-lane
// shift timers, and a single-issue FSM that pairs every lane shift or frog move with one collision check.
module sc_lane_scheduler #(
   parameter int TICK_DIV    = 2_500_000,
   parameter int NUM_LANES   = 4,
   parameter int BASE_PERIOD = 3,
   parameter int LANE_SKEW   = 1
) (
   input  logic                 SC_LANE_SCHEDULER_CLOCK_50,
   input  logic                 SC_LANE_SCHEDULER_RESET_InHigh,
   input  logic                 SC_LANE_SCHEDULER_clear_InLow,
   input  logic                 SC_LANE_SCHEDULER_run_InHigh,
   input  logic [3:0]           SC_LANE_SCHEDULER_level_In,
   input  logic                 SC_LANE_SCHEDULER_frogReq_InHigh,
   input  logic                 SC_LANE_SCHEDULER_checkDone_InHigh,
   input  logic                 SC_LANE_SCHEDULER_collision_InHigh,
   output logic [NUM_LANES-1:0] SC_LANE_SCHEDULER_laneShift_Out,
   output logic                 SC_LANE_SCHEDULER_frogAck_OutHigh,
   output logic                 SC_LANE_SCHEDULER_checkStart_OutHigh,
   output logic                 SC_LANE_SCHEDULER_gameOver_OutHigh,
   output logic                 SC_LANE_SCHEDULER_busy_OutHigh
);

   localparam int                PS_W    = $clog2(TICK_DIV);
   localparam logic [PS_W-1:0]   PS_LAST = PS_W'(TICK_DIV - 1);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_FROG     = 3'd1;
   localparam logic [2:0] ST_SHIFT    = 3'd2;
   localparam logic [2:0] ST_CHKSTART = 3'd3;
   localparam logic [2:0] ST_CHKWAIT  = 3'd4;
   localparam logic [2:0] ST_HALT     = 3'd5;

   logic [2:0]           r_state;
   logic [2:0]           w_state_next;
   logic [PS_W-1:0]      r_presc;
   logic [NUM_LANES-1:0] r_due;
   logic [NUM_LANES-1:0] w_new_due;
   logic                 r_frog_pend;
   logic                 w_srst;
   logic                 w_presc_en;
   logic                 w_tick;

   // Game clear from the general FSM is a second, active-low synchronous reset.
   assign w_srst     = SC_LANE_SCHEDULER_RESET_InHigh | ~SC_LANE_SCHEDULER_clear_InLow;
   assign w_presc_en = SC_LANE_SCHEDULER_run_InHigh && (r_state != ST_HALT);
   assign w_tick     = w_presc_en && (r_presc == PS_LAST);

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [8:0] LP_NOMINAL = 9'(BASE_PERIOD + LANE_SKEW * gi);

      logic [8:0] w_diff;
      logic [7:0] w_period;
      logic [7:0] r_cnt;

      // Bit 8 of the difference is the sign; zero or negative periods clamp to one tick.
      assign w_diff         = LP_NOMINAL - {5'd0, SC_LANE_SCHEDULER_level_In};
      assign w_period       = (w_diff[8] || (w_diff == 9'd0)) ? 8'd1 : w_diff[7:0];
      assign w_new_due[gi]  = w_tick && (r_cnt <= 8'd1);

      always_ff @(posedge SC_LANE_SCHEDULER_CLOCK_50) begin
         if (w_srst) begin
            r_cnt <= w_period;
         end else if (w_tick) begin
            r_cnt <= (r_cnt <= 8'd1) ? w_period : r_cnt - 8'd1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (SC_LANE_SCHEDULER_run_InHigh && r_frog_pend) begin
               w_state_next = ST_FROG;
            end else if (SC_LANE_SCHEDULER_run_InHigh && (|r_due)) begin
               w_state_next = ST_SHIFT;
            end
         end
         ST_FROG:     w_state_next = ST_CHKSTART;
         ST_SHIFT:    w_state_next = ST_CHKSTART;
         ST_CHKSTART: w_state_next = ST_CHKWAIT;
         ST_CHKWAIT: begin
            if (SC_LANE_SCHEDULER_checkDone_InHigh) begin
               w_state_next = SC_LANE_SCHEDULER_collision_InHigh ? ST_HALT : ST_IDLE;
            end
         end
         ST_HALT:     w_state_next = ST_HALT;
         default:     w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge SC_LANE_SCHEDULER_CLOCK_50) begin
      if (w_srst) begin
         r_state     <= ST_IDLE;
         r_presc     <= '0;
         r_due       <= '0;
         r_frog_pend <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_presc_en) begin
            r_presc <= (r_presc == PS_LAST) ? '0 : r_presc + PS_W'(1);
         end
         // The SHIFT cycle consumes the mask, but a lane falling due in that same cycle is kept.
         r_due       <= ((r_state == ST_SHIFT) ? '0 : r_due) | w_new_due;
         r_frog_pend <= (SC_LANE_SCHEDULER_frogReq_InHigh & SC_LANE_SCHEDULER_run_InHigh)
                      | (r_frog_pend & (r_state != ST_FROG));
      end
   end

   assign SC_LANE_SCHEDULER_laneShift_Out      = (r_state == ST_SHIFT) ? r_due : '0;
   assign SC_LANE_SCHEDULER_frogAck_OutHigh    = (r_state == ST_FROG);
   assign SC_LANE_SCHEDULER_checkStart_OutHigh = (r_state == ST_CHKSTART);
   assign SC_LANE_SCHEDULER_gameOver_OutHigh   = (r_state == ST_HALT);
   assign SC_LANE_SCHEDULER_busy_OutHigh       = (r_state == ST_FROG) || (r_state == ST_SHIFT)
                                              || (r_state == ST_CHKSTART) || (r_state == ST_CHKWAIT);

endmodule

// File: tb/tb_sc_lane_scheduler.sv
// Directed bench for sc_lane_scheduler with TICK_DIV=4; a collision checker that
// answers two cycles after checkStart is modelled inside the per-cycle step task.
module tb_sc_lane_scheduler;

   localparam int NL = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr_n;
   logic          run;
   logic [3:0]    level;
   logic          frog_req;
   logic          chk_done;
   logic          coll;
   logic [NL-1:0] lane_shift;
   logic          frog_ack;
   logic          chk_start;
   logic          game_over;
   logic          busy;

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc;
   int            cd_cnt;
   logic          coll_val;
   int            ls_cyc[$];
   logic [NL-1:0] ls_val[$];
   int            start_cyc[$];
   int            n_ack;
   int            ack_cyc;
   int            n_start;

   int            a_cyc [10] = '{13, 18, 23, 28, 33, 38, 43, 49, 61, 66};
   logic [NL-1:0] a_val [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0010,
                                 4'b0001, 4'b0100, 4'b1011, 4'b0101, 4'b0010};

   always #5 clk = ~clk;

   sc_lane_scheduler #(
      .TICK_DIV    (4),
      .NUM_LANES   (NL),
      .BASE_PERIOD (3),
      .LANE_SKEW   (1)
   ) dut (
      .SC_LANE_SCHEDULER_CLOCK_50          (clk),
      .SC_LANE_SCHEDULER_RESET_InHigh      (rst),
      .SC_LANE_SCHEDULER_clear_InLow       (clr_n),
      .SC_LANE_SCHEDULER_run_InHigh        (run),
      .SC_LANE_SCHEDULER_level_In          (level),
      .SC_LANE_SCHEDULER_frogReq_InHigh    (frog_req),
      .SC_LANE_SCHEDULER_checkDone_InHigh  (chk_done),
      .SC_LANE_SCHEDULER_collision_InHigh  (coll),
      .SC_LANE_SCHEDULER_laneShift_Out     (lane_shift),
      .SC_LANE_SCHEDULER_frogAck_OutHigh   (frog_ack),
      .SC_LANE_SCHEDULER_checkStart_OutHigh(chk_start),
      .SC_LANE_SCHEDULER_gameOver_OutHigh  (game_over),
      .SC_LANE_SCHEDULER_busy_OutHigh      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_log();
      ls_cyc.delete();
      ls_val.delete();
      start_cyc.delete();
      n_ack   = 0;
      ack_cyc = -1;
      n_start = 0;
   endtask

   // One clock: sample just after the edge, log pulses, play the collision checker.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      frog_req = 1'b0;
      chk_done = 1'b0;
      coll     = 1'b0;
      if (cd_cnt > 0) begin
         cd_cnt--;
         if (cd_cnt == 0) begin
            chk_done = 1'b1;
            coll     = coll_val;
         end
      end
      if (chk_start) begin
         cd_cnt = 2;
         n_start++;
         start_cyc.push_back(cyc);
      end
      if (frog_ack) begin
         n_ack++;
         ack_cyc = cyc;
      end
      if (lane_shift != '0) begin
         ls_cyc.push_back(cyc);
         ls_val.push_back(lane_shift);
      end
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   // Leaves the bench in cycle 0: reset released, prescaler at 0.
   task automatic do_reset();
      rst      = 1'b1;
      cd_cnt   = 0;
      chk_done = 1'b0;
      coll     = 1'b0;
      frog_req = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      clr_log();
   endtask

   function automatic int ls_cyc_at(input int i);
      if (i < ls_cyc.size()) return ls_cyc[i];
      return -1;
   endfunction

   function automatic logic [NL-1:0] ls_val_at(input int i);
      if (i < ls_val.size()) return ls_val[i];
      return '0;
   endfunction

   function automatic int start_at(input int i);
      if (i < start_cyc.size()) return start_cyc[i];
      return -1;
   endfunction

   initial begin
      rst = 1'b1; clr_n = 1'b1; run = 1'b1; level = 4'd0; frog_req = 1'b0;
      chk_done = 1'b0; coll = 1'b0; coll_val = 1'b0; cd_cnt = 0; cyc = 0;
      clr_log();

      // Level 0 lane schedule, including merged simultaneous dues
      do_reset();
      chk("rst_lane_shift", lane_shift, 0);
      chk("rst_frog_ack", frog_ack, 0);
      chk("rst_chk_start", chk_start, 0);
      chk("rst_game_over", game_over, 0);
      chk("rst_busy", busy, 0);
      run_to(70);
      chk("a_count", ls_cyc.size(), 10);
      chk("a_starts", n_start, 10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("a_cyc%0d", i), ls_cyc_at(i), a_cyc[i]);
         chk($sformatf("a_val%0d", i), ls_val_at(i), a_val[i]);
      end

      // Level 5: every period clamps to one tick
      level = 4'd5;
      do_reset();
      run_to(42);
      chk("b_count", ls_cyc.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("b_cyc%0d", i), ls_cyc_at(i), 5 * (i + 1));
         chk($sformatf("b_val%0d", i), ls_val_at(i), 4'b1111);
      end

      // Frog request in the tick cycle that makes lane 0 due: frog goes first
      level = 4'd0;
      do_reset();
      run_to(11);
      frog_req = 1'b1;
      run_to(22);
      chk("c_acks", n_ack, 1);
      chk("c_ack_cyc", ack_cyc, 13);
      chk("c_starts", n_start, 2);
      chk("c_start0", start_at(0), 14);
      chk("c_start1", start_at(1), 19);
      chk("c_shifts", ls_cyc.size(), 1);
      chk("c_shift_cyc", ls_cyc_at(0), 18);
      chk("c_shift_val", ls_val_at(0), 4'b0011);

      // Collision halts play until clear
      do_reset();
      coll_val = 1'b1;
      run_to(16);
      chk("d_go_before", game_over, 0);
      step();
      chk("d_go_set", game_over, 1);
      chk("d_busy_halt", busy, 0);
      clr_log();
      for (int i = 0; i < 200; i++) begin
         step();
         if (i % 50 == 10) frog_req = 1'b1;
      end
      chk("d_halt_shifts", ls_cyc.size(), 0);
      chk("d_halt_acks", n_ack, 0);
      chk("d_halt_starts", n_start, 0);
      chk("d_go_hold", game_over, 1);
      clr_n = 1'b0;
      step();
      chk("d_go_clear", game_over, 0);
      chk("d_busy_clear", busy, 0);
      clr_n    = 1'b1;
      coll_val = 1'b0;
      cyc      = 0;
      clr_log();
      run_to(14);
      chk("d_post_acks", n_ack, 0);
      chk("d_post_cyc", ls_cyc_at(0), 13);
      chk("d_post_val", ls_val_at(0), 4'b0001);

      // run dropped in CHKWAIT: transaction finishes, prescaler freezes at 3
      do_reset();
      run_to(15);
      run = 1'b0;
      chk("e_busy_wait", busy, 1);
      run_to(17);
      chk("e_busy_done", busy, 0);
      chk("e_start0", start_at(0), 14);
      clr_log();
      run_to(20);
      frog_req = 1'b1;
      run_to(44);
      chk("e_idle_shifts", ls_cyc.size(), 0);
      chk("e_idle_acks", n_ack, 0);
      chk("e_idle_starts", n_start, 0);
      run = 1'b1;
      run_to(47);
      chk("e_resume_count", ls_cyc.size(), 1);
      chk("e_resume_cyc", ls_cyc_at(0), 46);
      chk("e_resume_val", ls_val_at(0), 4'b0010);

      // Reset during SHIFT clears outputs, due mask and frog pending
      do_reset();
      run_to(12);
      frog_req = 1'b1;
      step();
      chk("f_in_shift", lane_shift, 4'b0001);
      rst = 1'b1;
      step();
      chk("f_lane_shift", lane_shift, 0);
      chk("f_busy", busy, 0);
      chk("f_frog_ack", frog_ack, 0);
      chk("f_chk_start", chk_start, 0);
      chk("f_game_over", game_over, 0);
      rst    = 1'b0;
      cyc    = 0;
      cd_cnt = 0;
      clr_log();
      run_to(14);
      chk("f_acks", n_ack, 0);
      chk("f_count", ls_cyc.size(), 1);
      chk("f_first_cyc", ls_cyc_at(0), 13);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
